// File: rtl/psram_arbiter_pkg.sv
// Shared types for the PSRAM arbiter: grant FSM states, port identifiers and
// the round-robin winner selection.
package psram_arbiter_pkg;

  typedef enum bit [2:0] {
    WAIT_CALIB = 3'd0,
    IDLE       = 3'd1,
    GRANT_WR   = 3'd2,
    GRANT_RD   = 3'd3,
    RELEASE    = 3'd4
  } t_state;

  typedef enum bit {
    PORT_WR = 1'b0,
    PORT_RD = 1'b1
  } t_port;

  // Only meaningful when at least one request is high; a tie goes to the port
  // that did not win last time.
  function automatic t_port pick_port(input logic wr_rq, input logic rd_rq,
                                      input t_port last_grant);
    t_port winner;
    winner = PORT_WR;
    if (wr_rq && rd_rq) begin
      winner = (last_grant == PORT_WR) ? PORT_RD : PORT_WR;
    end else if (rd_rq) begin
      winner = PORT_RD;
    end
    return winner;
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Bus bundle between the frame writer, the frame reader, the arbiter and the
// PSRAM controller. The slave modport is the arbiter's view.
interface psram_arbiter_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
);

  logic                    wr_rq;
  logic                    wr_ack;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic                    rd_rq;
  logic                    rd_ack;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_data_valid;

  logic                    mem_cmd;
  logic                    mem_cmd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH/8-1:0] mem_data_mask;
  logic [DATA_WIDTH-1:0]   mem_rd_data;
  logic                    mem_rd_data_valid;

  modport slave (
    input  wr_rq, wr_en, wr_addr, wr_data,
    input  rd_rq, rd_en, rd_addr,
    input  mem_rd_data, mem_rd_data_valid,
    output wr_ack, rd_ack, rd_data, rd_data_valid,
    output mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask
  );

  modport master (
    output wr_rq, wr_en, wr_addr, wr_data,
    output rd_rq, rd_en, rd_addr,
    output mem_rd_data, mem_rd_data_valid,
    input  wr_ack, rd_ack, rd_data, rd_data_valid,
    input  mem_cmd, mem_cmd_en, mem_addr, mem_wr_data, mem_data_mask
  );

endinterface

// File: rtl/psram_arbiter.sv
// Shares one PSRAM controller between the frame writer and the frame reader:
// calibration gate, round-robin grant FSM with watchdog, and command mux.
module psram_arbiter
  import psram_arbiter_pkg::*;
#(
`ifdef __ICARUS__
  parameter string MODULE_NAME   = "psram_arbiter",
  parameter int    LOG_LEVEL     = 1,
`endif
  parameter int    ADDR_WIDTH    = 21,
  parameter int    DATA_WIDTH    = 32,
  parameter int    GRANT_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 calib_done,
  psram_arbiter_if.slave       bus,
  output logic                 timeout_err,
  output t_state               dbg_state
);

  localparam int             CW       = (GRANT_TIMEOUT > 2) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam logic [CW-1:0]  HOLD_MAX = CW'(GRANT_TIMEOUT - 1);
  localparam int             MASK_W   = DATA_WIDTH / 8;

  t_state        state;
  t_port         last_grant;
  t_port         winner;
  logic [CW-1:0] hold_cnt;
  logic          hold_last;
  logic          wr_ack_r;
  logic          rd_ack_r;
  logic          timeout_err_r;

  assign winner    = pick_port(bus.wr_rq, bus.rd_rq, last_grant);
  assign hold_last = (hold_cnt == HOLD_MAX);

  // Handshake: a requester raises x_rq and holds it for its whole burst; x_ack
  // is high exactly while the grant is held, and x_en is honoured only then.
  // Dropping x_rq (or the watchdog) ends the grant; one turnaround cycle follows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_CALIB;
      last_grant    <= PORT_WR;
      hold_cnt      <= '0;
      wr_ack_r      <= 1'b0;
      rd_ack_r      <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state)
        WAIT_CALIB: begin
          if (calib_done) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!calib_done) begin
            state <= WAIT_CALIB;
          end else if (bus.wr_rq || bus.rd_rq) begin
            hold_cnt   <= '0;
            last_grant <= winner;
            if (winner == PORT_WR) begin
              state    <= GRANT_WR;
              wr_ack_r <= 1'b1;
            end else begin
              state    <= GRANT_RD;
              rd_ack_r <= 1'b1;
            end
          end
        end
        GRANT_WR: begin
          if (!bus.wr_rq || hold_last) begin
            state    <= RELEASE;
            wr_ack_r <= 1'b0;
            if (bus.wr_rq) begin
              timeout_err_r <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        GRANT_RD: begin
          if (!bus.rd_rq || hold_last) begin
            state    <= RELEASE;
            rd_ack_r <= 1'b0;
            if (bus.rd_rq) begin
              timeout_err_r <= 1'b1;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: begin
          // Calibration lost during a grant sends us back to wait for it.
          state <= calib_done ? IDLE : WAIT_CALIB;
        end
        default: begin
          state <= WAIT_CALIB;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_cmd     = 1'b0;
    bus.mem_cmd_en  = 1'b0;
    bus.mem_addr    = {ADDR_WIDTH{1'b0}};
    bus.mem_wr_data = {DATA_WIDTH{1'b0}};
    case (state)
      GRANT_WR: begin
        bus.mem_cmd     = 1'b1;
        bus.mem_cmd_en  = bus.wr_en;
        bus.mem_addr    = bus.wr_addr;
        bus.mem_wr_data = bus.wr_data;
      end
      GRANT_RD: begin
        bus.mem_cmd_en  = bus.rd_en;
        bus.mem_addr    = bus.rd_addr;
      end
      default: begin
      end
    endcase
  end

  // The controller only returns data for reads, so no ownership tracking.
  assign bus.rd_data       = bus.mem_rd_data;
  assign bus.rd_data_valid = bus.mem_rd_data_valid;
  assign bus.mem_data_mask = {MASK_W{1'b0}};
  assign bus.wr_ack        = wr_ack_r;
  assign bus.rd_ack        = rd_ack_r;
  assign timeout_err       = timeout_err_r;
  assign dbg_state         = state;

`ifdef __ICARUS__
  logic grant_evt;
  logic timeout_evt;

  assign grant_evt   = (state == IDLE) && calib_done && (bus.wr_rq || bus.rd_rq);
  assign timeout_evt = hold_last && (((state == GRANT_WR) && bus.wr_rq) ||
                                     ((state == GRANT_RD) && bus.rd_rq));

  psram_logger #(
    .MODULE_NAME (MODULE_NAME),
    .LOG_LEVEL   (LOG_LEVEL)
  ) u_logger (
    .clk         (clk),
    .grant_evt   (grant_evt),
    .grant_port  (winner),
    .timeout_evt (timeout_evt)
  );
`endif

endmodule
